// File: rtl/input_port_request_unit.sv
// Router input port: flit FIFO, XY route computation on the head flit, and the
// dst/en request pair into the switch allocator, held for one wormhole packet.
`ifndef EMPTY
`define EMPTY          3'd0
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd1
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT    3'd2
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT    3'd3
`endif

module input_port_request_unit #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int X_W     = 1,
  parameter int Y_W     = 2,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_flit,
  output logic              in_ready,
  output logic [2:0]        req_dst,
  output logic              req_en,
  input  logic              sa_grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit,
  output logic              err_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [X_W-1:0] LX = X_W'(LOCAL_X);
  localparam logic [Y_W-1:0] LY = Y_W'(LOCAL_Y);

  // Handshake: a flit moves upstream->FIFO when in_valid && in_ready; a flit
  // leaves to the crossbar on any cycle with sa_grant && out_valid.
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state, state_next;
  logic [2:0]        req_dst_next;
  logic              req_en_next, err_drop_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop;
  logic [DATA_W-1:0] front;
  logic [1:0]        front_type;
  logic [X_W-1:0]    dst_x;
  logic [Y_W-1:0]    dst_y;
  logic [2:0]        route;
  logic              front_is_head, front_is_last;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign front    = mem[rd_ptr[AW-1:0]];
  assign out_flit = empty ? '0 : front;

  assign front_type    = front[DATA_W-1:DATA_W-2];
  assign front_is_head = (front_type == 2'b01) || (front_type == 2'b11);
  assign front_is_last = (front_type == 2'b10) || (front_type == 2'b11);
  assign dst_x         = front[X_W+Y_W-1:Y_W];
  assign dst_y         = front[Y_W-1:0];

  always_comb begin
    if (dst_x != LX)      route = `OUT_X1_PORT;
    else if (dst_y != LY) route = `OUT_Y1_PORT;
    else                  route = `OUT_LOCAL_PORT;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      req_dst  <= `EMPTY;
      req_en   <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state    <= state_next;
      req_dst  <= req_dst_next;
      req_en   <= req_en_next;
      err_drop <= err_drop_next;
    end
  end

  always_comb begin
    state_next    = state;
    req_dst_next  = req_dst;
    req_en_next   = 1'b0;
    err_drop_next = 1'b0;
    pop           = 1'b0;
    out_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (front_is_head) begin
            req_dst_next = route;
            req_en_next  = 1'b1;
            state_next   = ACTIVE;
          end else begin
            // Orphan body/tail with no route: discard so the port cannot wedge.
            pop           = 1'b1;
            err_drop_next = 1'b1;
          end
        end
      end
      ACTIVE: begin
        out_valid = !empty;
        if (sa_grant && !empty) begin
          pop = 1'b1;
          if (front_is_last) begin
            req_dst_next = `EMPTY;
            req_en_next  = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_port_request_unit.sv
// Bench for input_port_request_unit: queue-based reference model checked every
// cycle, plus directed packet scenarios with literal expectations.
`ifndef EMPTY
`define EMPTY          3'd0
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd1
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT    3'd2
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT    3'd3
`endif

module tb_input_port_request_unit;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_flit  = '0;
  logic              in_ready;
  logic [2:0]        req_dst;
  logic              req_en;
  logic              sa_grant = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_flit;
  logic              err_drop;

  input_port_request_unit #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .X_W(1), .Y_W(2), .LOCAL_X(0), .LOCAL_Y(0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .req_dst(req_dst), .req_en(req_en), .sa_grant(sa_grant), .out_valid(out_valid),
    .out_flit(out_flit), .err_drop(err_drop)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input logic x,
                                           input logic [1:0] y, input logic [26:0] pay);
    return {t, pay, x, y};
  endfunction

  // reference model: packet queue plus "in a packet" flag
  logic [DATA_W-1:0] exp_q[$];
  bit                m_act;
  logic [2:0]        m_req_dst;
  bit                m_req_en, m_err;

  function automatic logic [2:0] xy_route(input logic [DATA_W-1:0] f);
    if (f[2] != 1'b0)        return `OUT_X1_PORT;
    else if (f[1:0] != 2'd0) return `OUT_Y1_PORT;
    else                     return `OUT_LOCAL_PORT;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_act = 0; m_req_dst = `EMPTY; m_req_en = 0; m_err = 0;
    end else begin
      bit may_push;
      logic [1:0] t;
      logic [DATA_W-1:0] f;
      may_push = in_valid && (exp_q.size() < DEPTH);
      m_req_en = 0;
      m_err    = 0;
      if (exp_q.size() > 0) begin
        t = exp_q[0][DATA_W-1:DATA_W-2];
        if (!m_act) begin
          if (t == 2'b01 || t == 2'b11) begin
            m_req_dst = xy_route(exp_q[0]); m_req_en = 1; m_act = 1;
          end else begin
            f = exp_q.pop_front(); m_err = 1;
          end
        end else if (sa_grant) begin
          f = exp_q.pop_front();
          if (t == 2'b10 || t == 2'b11) begin
            m_req_dst = `EMPTY; m_req_en = 1; m_act = 0;
          end
        end
      end
      if (may_push) exp_q.push_back(in_flit);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("in_ready",  in_ready,  (exp_q.size() < DEPTH));
      chk("out_valid", out_valid, (m_act && exp_q.size() > 0));
      chk("out_flit",  out_flit,  (exp_q.size() > 0) ? exp_q[0] : '0);
      chk("req_dst",   req_dst,   m_req_dst);
      chk("req_en",    req_en,    m_req_en);
      chk("err_drop",  err_drop,  m_err);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_flit(input logic [DATA_W-1:0] f);
    in_valid = 1'b1; in_flit = f;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic grant(input int n);
    sa_grant = 1'b1;
    step(n);
    sa_grant = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() > 0 || m_act); i++) begin
      sa_grant = m_act && exp_q.size() > 0;
      step(1);
    end
    sa_grant = 1'b0;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] h, b1, b2, tl;
    run_cmp = 1'b1;
    step(2);
    chk("rst_req_dst", req_dst, `EMPTY);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_flit", out_flit, 0);
    rst = 1'b0;
    step(1);

    // 1: single flit dst(1,2) -> X route, then EMPTY after grant
    h = mk(2'b11, 1'b1, 2'd2, 27'h11);
    push_flit(h);
    step(1);
    chk("t1_req_en", req_en, 1);
    chk("t1_req_dst", req_dst, `OUT_X1_PORT);
    step(1);
    chk("t1_req_en_pulse", req_en, 0);
    chk("t1_out_flit", out_flit, h);
    grant(1);
    chk("t1_empty_dst", req_dst, `EMPTY);
    chk("t1_empty_en", req_en, 1);
    chk("t1_out_valid", out_valid, 0);
    step(2);

    // 2: 4-flit packet dst(0,3) -> Y route held, popped in order
    h = mk(2'b01, 1'b0, 2'd3, 27'h21); b1 = mk(2'b00, 1'b0, 2'd0, 27'h22);
    b2 = mk(2'b00, 1'b1, 2'd1, 27'h23); tl = mk(2'b10, 1'b0, 2'd2, 27'h24);
    push_flit(h); push_flit(b1); push_flit(b2); push_flit(tl);
    step(1);
    chk("t2_req_dst", req_dst, `OUT_Y1_PORT);
    chk("t2_front_head", out_flit, h);
    grant(1); chk("t2_front_b1", out_flit, b1); chk("t2_held", req_dst, `OUT_Y1_PORT);
    grant(1); chk("t2_front_b2", out_flit, b2);
    grant(1); chk("t2_front_tail", out_flit, tl);
    grant(1);
    chk("t2_tail_dst", req_dst, `EMPTY);
    chk("t2_tail_en", req_en, 1);
    step(2);

    // 3: local head, gap with grants while empty, then body/tail
    h = mk(2'b01, 1'b0, 2'd0, 27'h31); b1 = mk(2'b00, 1'b0, 2'd0, 27'h32);
    tl = mk(2'b10, 1'b0, 2'd0, 27'h33);
    push_flit(h);
    step(1);
    chk("t3_req_dst", req_dst, `OUT_LOCAL_PORT);
    grant(1);
    grant(3);
    chk("t3_gap_valid", out_valid, 0);
    chk("t3_gap_route", req_dst, `OUT_LOCAL_PORT);
    push_flit(b1); push_flit(tl);
    grant(2);
    chk("t3_end_dst", req_dst, `EMPTY);
    step(2);

    // 4: fill past depth, full+pop refusal, three fill/drain rounds for wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) push_flit(mk(2'b11, i[0], i[1:0] + 2'(r), 27'(16 * r + i)));
      in_valid = 1'b1; in_flit = mk(2'b11, 1'b0, 2'd1, 27'h7ff);
      chk("t4_full", in_ready, 0);
      step(1);
      chk("t4_refused", exp_q.size(), 4);
      sa_grant = 1'b1;
      step(1);
      sa_grant = 1'b0; in_valid = 1'b0;
      chk("t4_pop_no_push", in_ready, 1);
      drain(40);
      step(1);
    end

    // 5: orphan body in IDLE is dropped
    push_flit(mk(2'b00, 1'b1, 2'd1, 27'h51));
    step(1);
    chk("t5_err_drop", err_drop, 1);
    chk("t5_no_req", req_en, 0);
    step(2);

    // 6: reset mid-packet, then a fresh single flit routes normally
    push_flit(mk(2'b01, 1'b1, 2'd0, 27'h61)); push_flit(mk(2'b00, 1'b0, 2'd0, 27'h62));
    push_flit(mk(2'b00, 1'b0, 2'd0, 27'h63)); push_flit(mk(2'b10, 1'b0, 2'd0, 27'h64));
    step(1);
    grant(2);
    rst = 1'b1;
    #1;
    chk("t6_rst_dst", req_dst, `EMPTY);
    chk("t6_rst_en", req_en, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    step(2);
    rst = 1'b0;
    step(1);
    push_flit(mk(2'b11, 1'b0, 2'd1, 27'h65));
    step(1);
    chk("t6_new_dst", req_dst, `OUT_Y1_PORT);
    chk("t6_new_en", req_en, 1);
    drain(10);
    step(2);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
